// File: rtl/hexfont_pkg.sv
// hexfont_pkg: shared types and constants for the hex font streamer.
// Optional build macro: HEXFONT_LEADING_ZERO_BLANK_EN.
package hexfont_pkg;

  // Segment patterns, bit6=a .. bit0=g; bit7 (dp) is added later.
  localparam logic [7:0] FONT [16] = '{
    8'h7E, 8'h30, 8'h6D, 8'h79,
    8'h33, 8'h5B, 8'h5F, 8'h70,
    8'h7F, 8'h7B, 8'h77, 8'h1F,
    8'h0D, 8'h3D, 8'h4F, 8'h47
  };

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT
  } state_e;

  // MAX7219 register address of the rightmost digit.
  localparam logic [3:0] DIG_ADDR_BASE = 4'd1;

  function automatic logic [15:0] pack_cmd(
    input logic [3:0] addr,
    input logic [7:0] seg
  );
    return {4'h0, addr, seg};
  endfunction

endpackage

// File: rtl/hexfont_digit_enc.sv
// hexfont_digit_enc: nibble + dp + blank -> MAX7219 segment byte.
// Blanking is driven by the parent (HEXFONT_LEADING_ZERO_BLANK_EN).
module hexfont_digit_enc
  import hexfont_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Glyph lookup; a blanked digit keeps its decimal point.
  always_comb begin
    seg_o = {dp_i, FONT[nib_i][6:0]};
    if (blank_i) seg_o[6:0] = 7'h00;
  end

endmodule

// File: rtl/hexfont_cmd_streamer.sv
// hexfont_cmd_streamer: streams changed MAX7219 digit writes.
// Define HEXFONT_LEADING_ZERO_BLANK_EN to blank leading zeros.
module hexfont_cmd_streamer
  import hexfont_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGITS*4-1:0] value_i,
  input  logic [DIGITS-1:0]   dp_i,
  input  logic                load_i,
  input  logic                invalidate_i,
  output logic                busy_o,
  output logic [15:0]         cmd_o,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i
);

  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  state_e                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [DIGITS*4-1:0]   snap_val_q, snap_val_d;
  logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [DIGITS*4-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pending_q, pending_d;
  logic [7:0]            shadow_q [DIGITS];
  logic [7:0]            shadow_d [DIGITS];
  logic [DIGITS-1:0]     shv_q, shv_d;
  logic [15:0]           cmd_q, cmd_d;
  logic                  cmd_valid_q, cmd_valid_d;

  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_blank;
  logic [7:0] cur_seg;
  logic       needs_send;
  logic       pass_end;

  // Select the snapshot digit under the scan index.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_nib = snap_val_q[4*i +: 4];
        cur_dp  = snap_dp_q[i];
      end
    end
`ifdef HEXFONT_LEADING_ZERO_BLANK_EN
    cur_blank = (idx_q != 3'd0) &&
                ((snap_val_q >> (4 * idx_q)) == '0);
`else
    cur_blank = 1'b0;
`endif
  end

  hexfont_digit_enc u_enc (
    .nib_i   (cur_nib),
    .dp_i    (cur_dp),
    .blank_i (cur_blank),
    .seg_o   (cur_seg)
  );

  assign needs_send = !shv_q[idx_q] ||
                      (shadow_q[idx_q] != cur_seg);

  // Next-state: scan, emit, pending pickup and invalidation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_val_d  = snap_val_q;
    snap_dp_d   = snap_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pending_d   = pending_q;
    shadow_d    = shadow_q;
    shv_d       = shv_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    pass_end    = 1'b0;

    if (load_i && state_q != IDLE) begin
      pending_d  = 1'b1;
      pend_val_d = value_i;
      pend_dp_d  = dp_i;
    end

    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          snap_val_d = value_i;
          snap_dp_d  = dp_i;
          idx_d      = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (needs_send) begin
          cmd_d       = pack_cmd(4'(idx_q) + DIG_ADDR_BASE,
                                 cur_seg);
          cmd_valid_d = 1'b1;
          state_d     = EMIT;
        end else if (idx_q != LAST) begin
          idx_d = idx_q + 3'd1;
        end else begin
          pass_end = 1'b1;
        end
      end
      EMIT: begin
        if (cmd_ready_i) begin
          shadow_d[idx_q] = cmd_q[7:0];
          shv_d[idx_q]    = 1'b1;
          cmd_valid_d     = 1'b0;
          if (idx_q != LAST) begin
            idx_d   = idx_q + 3'd1;
            state_d = SCAN;
          end else begin
            pass_end = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the pass-end cycle is newer than any pending one.
    if (pass_end) begin
      idx_d = '0;
      if (load_i) begin
        snap_val_d = value_i;
        snap_dp_d  = dp_i;
        pending_d  = 1'b0;
        state_d    = SCAN;
      end else if (pending_q) begin
        snap_val_d = pend_val_q;
        snap_dp_d  = pend_dp_q;
        pending_d  = 1'b0;
        state_d    = SCAN;
      end else begin
        state_d = IDLE;
      end
    end

    if (invalidate_i) shv_d = '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_val_q  <= '0;
      snap_dp_q   <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pending_q   <= 1'b0;
      shadow_q    <= '{default: '0};
      shv_q       <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_val_q  <= snap_val_d;
      snap_dp_q   <= snap_dp_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
      shv_q       <= shv_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;

endmodule

// File: tb/tb_hexfont_cmd_streamer.sv
// tb_hexfont_cmd_streamer: directed + random bench with a
// shadow-list reference model of the digit write stream.
module tb_hexfont_cmd_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value_i = '0;
  logic [7:0]  dp_i = '0;
  logic        load_i = 1'b0;
  logic        invalidate_i = 1'b0;
  logic        busy_o;
  logic [15:0] cmd_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i = 1'b1;

  int tests = 0;
  int fails = 0;

  logic [15:0] got[$];
  logic [15:0] expq[$];

  logic [7:0] font_t [16] = '{
    8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
    8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h0D, 8'h3D, 8'h4F, 8'h47
  };
  logic [7:0] m_sh [8];
  bit         m_shv [8];

  hexfont_cmd_streamer #(.DIGITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .value_i      (value_i),
    .dp_i         (dp_i),
    .load_i       (load_i),
    .invalidate_i (invalidate_i),
    .busy_o       (busy_o),
    .cmd_o        (cmd_o),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_ready_i  (cmd_ready_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && cmd_valid_o && cmd_ready_i)
      got.push_back(cmd_o);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) m_shv[i] = 1'b0;
  endfunction

  function automatic void model_load(input logic [31:0] v,
                                     input logic [7:0] d);
    logic [7:0] seg;
    for (int i = 0; i < 8; i++) begin
      seg = font_t[(v / (32'd1 << (4 * i))) % 16];
`ifdef HEXFONT_LEADING_ZERO_BLANK_EN
      if (i > 0 && v < (32'd1 << (4 * i))) seg = 8'h00;
`endif
      seg[7] = d[i];
      if (!m_shv[i] || m_sh[i] != seg) begin
        expq.push_back({4'h0, 4'(i + 1), seg});
        m_sh[i]  = seg;
        m_shv[i] = 1'b1;
      end
    end
  endfunction

  task automatic do_load(input logic [31:0] v,
                         input logic [7:0] d,
                         input bit inv);
    @(posedge clk); #1;
    value_i = v; dp_i = d; load_i = 1'b1; invalidate_i = inv;
    @(posedge clk); #1;
    load_i = 1'b0; invalidate_i = 1'b0;
  endtask

  task automatic run_pass(input bit rnd,
                          output int bcyc,
                          output int vcyc);
    bcyc = 0; vcyc = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!busy_o) break;
      bcyc++;
      if (cmd_valid_o) vcyc++;
      @(posedge clk); #1;
      if (rnd) cmd_ready_i = 1'($urandom_range(0, 1));
    end
    cmd_ready_i = 1'b1;
    chk("pass_done", 32'(busy_o), 32'd0);
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_cnt"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk(tag, 32'(got[i]), 32'(expq[i]));
    got.delete();
    expq.delete();
  endtask

  initial begin
    int bc, vc, w;
    logic [31:0] v, prev;
    logic [7:0]  d;
    bit inv;
    logic [15:0] t1 [8] = '{
      16'h013D, 16'h020D, 16'h031F, 16'h0477,
      16'h0579, 16'h066D, 16'h0730, 16'h087E
    };

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_cmd", 32'(cmd_o), 32'h0);
    chk("rst_valid", 32'(cmd_valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);

    do_load(32'h0123_ABCD, 8'h00, 1'b0);
    model_load(32'h0123_ABCD, 8'h00);
    @(negedge clk);
    chk("lat_busy", 32'(busy_o), 32'd1);
    chk("lat_n1", 32'(cmd_valid_o), 32'd0);
    @(negedge clk);
    chk("lat_n2", 32'(cmd_valid_o), 32'd1);
    chk("lat_cmd", 32'(cmd_o), 32'(expq[0]));
    run_pass(1'b0, bc, vc);
`ifndef HEXFONT_LEADING_ZERO_BLANK_EN
    chk("full_cnt", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("full_lit", 32'(got[i]), 32'(t1[i]));
`endif
    compare_q("full");

    do_load(32'h0123_ABCE, 8'h00, 1'b0);
    model_load(32'h0123_ABCE, 8'h00);
    run_pass(1'b0, bc, vc);
    chk("one_cnt", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("one_lit", 32'(got[0]), 32'h014F);
    compare_q("one");

    do_load(32'h0123_ABCE, 8'h00, 1'b0);
    model_load(32'h0123_ABCE, 8'h00);
    run_pass(1'b0, bc, vc);
    chk("same_busy", 32'(bc), 32'd8);
    chk("same_valid", 32'(vc), 32'd0);
    compare_q("same");

    cmd_ready_i = 1'b0;
    do_load(32'h0123_ABCD, 8'h00, 1'b0);
    model_load(32'h0123_ABCD, 8'h00);
    w = 0;
    while (!cmd_valid_o && w < 12) begin
      @(negedge clk); w++;
    end
    chk("bp_valid", 32'(cmd_valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_v", 32'(cmd_valid_o), 32'd1);
      chk("bp_hold_c", 32'(cmd_o), 32'h013D);
    end
    chk("bp_none", 32'(got.size()), 32'd0);
    @(posedge clk); #1;
    cmd_ready_i = 1'b1;
    run_pass(1'b0, bc, vc);
    compare_q("bp");

    @(posedge clk); #1;
    value_i = 32'h89AB_CDEF; dp_i = 8'h00; load_i = 1'b1;
    @(posedge clk); #1;
    value_i = 32'h1111_1111;
    @(posedge clk); #1;
    value_i = 32'h2222_2222;
    @(posedge clk); #1;
    load_i = 1'b0;
    model_load(32'h89AB_CDEF, 8'h00);
    model_load(32'h2222_2222, 8'h00);
    run_pass(1'b0, bc, vc);
    compare_q("pend");

    do_load(32'h2222_2222, 8'h00, 1'b1);
    model_clear();
    model_load(32'h2222_2222, 8'h00);
    run_pass(1'b0, bc, vc);
    chk("inv_cnt", 32'(got.size()), 32'd8);
    compare_q("inv");

    cmd_ready_i = 1'b0;
    do_load(32'h3333_3333, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_v", 32'(cmd_valid_o), 32'd1);
    @(posedge clk); #1;
    value_i = 32'h4444_4444; load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_v", 32'(cmd_valid_o), 32'd0);
    chk("rst_mid_c", 32'(cmd_o), 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_nopend", 32'(busy_o), 32'd0);
    chk("rst_nohs", 32'(got.size()), 32'd0);
    got.delete();
    model_clear();
    cmd_ready_i = 1'b1;
    do_load(32'h3333_3333, 8'h00, 1'b0);
    model_load(32'h3333_3333, 8'h00);
    run_pass(1'b0, bc, vc);
    chk("rst_resend", 32'(got.size()), 32'd8);
    compare_q("rst_re");

`ifdef HEXFONT_LEADING_ZERO_BLANK_EN
    do_load(32'h0000_00A5, 8'h00, 1'b1);
    model_clear();
    model_load(32'h0000_00A5, 8'h00);
    run_pass(1'b0, bc, vc);
    chk("blk_cnt", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("blk_lit", 32'(got[i]),
          (i == 0) ? 32'h015B :
          (i == 1) ? 32'h0277 : 32'((i + 1) << 8));
    compare_q("blk");
    do_load(32'h0, 8'h00, 1'b0);
    model_load(32'h0, 8'h00);
    run_pass(1'b0, bc, vc);
    if (got.size() > 0) chk("blk_zero", 32'(got[0]), 32'h017E);
    compare_q("blk0");
`endif

    prev = 32'h2222_2222;
    for (int n = 0; n < 24; n++) begin
      v = $urandom;
      v = v >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) v = prev;
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) d = 8'h00;
      inv = ($urandom_range(0, 4) == 0);
      prev = v;
      do_load(v, d, inv);
      if (inv) model_clear();
      model_load(v, d);
      run_pass(1'b1, bc, vc);
      compare_q("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
